// File: rtl/banzai_seq_ctrl.sv
// Multi-channel array command sequencer: FIFO-buffered commands, per-channel power-up settle, issue/wait/respond.
// Powered channel: push to chip_start in 2 cycles; cmd_ready drops when the FIFO is full, responses hold until rsp_ready.
module banzai_seq_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int PWR_UP_CYCLES = 16,
  parameter int TIMEOUT       = 1023,
  parameter int IDLE_OFF      = 256,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [1:0]               rsp_status,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     busy,
  output logic [NUM_CH-1:0]        pwr_en,
  output logic [NUM_CH-1:0]        chip_sel,
  output logic [1:0]               chip_op,
  output logic [ADDR_W-1:0]        chip_addr,
  output logic [DATA_W-1:0]        chip_wdata,
  output logic                     chip_start,
  input  logic [NUM_CH-1:0]        chip_done,
  input  logic [NUM_CH*DATA_W-1:0] chip_rdata
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_MAX = (PWR_UP_CYCLES > TIMEOUT) ? PWR_UP_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDL_W   = (IDLE_OFF > 1) ? $clog2(IDLE_OFF + 1) : 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_PWR_UP, S_ISSUE, S_WAIT, S_RESP} state_t;

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push, pop;
  cmd_t             head, cur;
  logic             head_bad, head_act, act;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDL_W-1:0] idle_cnt [NUM_CH];
  logic [NUM_CH-1:0] held;

  assign cmd_ready  = !rst && (level != LVL_W'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && (level != '0);
  assign head       = mem[rd_ptr];
  assign head_bad   = 32'(head.ch) >= NUM_CH;
  assign head_act   = !head_bad && (head.op != OP_NOP);
  assign fifo_level = level;
  assign busy       = (state != S_IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {cmd_ch, cmd_op, cmd_addr, cmd_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // A channel is held from the pop that claims it until its response is taken.
  always_comb begin
    held = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      held[i] = ((state != S_IDLE) && act && (cur.ch == CH_W'(i))) ||
                (pop && head_act && (head.ch == CH_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      act        <= 1'b0;
      cnt        <= '0;
      pwr_en     <= '0;
      chip_sel   <= '0;
      chip_op    <= '0;
      chip_addr  <= '0;
      chip_wdata <= '0;
      chip_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= '0;
      for (int i = 0; i < NUM_CH; i++) idle_cnt[i] <= '0;
    end else begin
      chip_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (held[i] || !pwr_en[i]) begin
          idle_cnt[i] <= '0;
        end else if (idle_cnt[i] == IDL_W'(IDLE_OFF - 1)) begin
          idle_cnt[i] <= '0;
          pwr_en[i]   <= 1'b0;
        end else begin
          idle_cnt[i] <= idle_cnt[i] + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            cur <= head;
            act <= head_act;
            cnt <= '0;
            if (!head_act) begin
              rsp_valid  <= 1'b1;
              rsp_data   <= '0;
              rsp_status <= head_bad ? 2'b10 : 2'b00;
              state      <= S_RESP;
            end else if (pwr_en[head.ch]) begin
              chip_sel   <= NUM_CH'(1) << head.ch;
              chip_op    <= head.op;
              chip_addr  <= head.addr;
              chip_wdata <= head.data;
              chip_start <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              pwr_en[head.ch] <= 1'b1;
              state           <= S_PWR_UP;
            end
          end
        end
        S_PWR_UP: begin
          if (cnt == CNT_W'(PWR_UP_CYCLES - 1)) begin
            chip_sel   <= NUM_CH'(1) << cur.ch;
            chip_op    <= cur.op;
            chip_addr  <= cur.addr;
            chip_wdata <= cur.data;
            chip_start <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done wins over a simultaneous timeout
          if (chip_done[cur.ch] || (cnt == CNT_W'(TIMEOUT))) begin
            rsp_valid  <= 1'b1;
            chip_sel   <= '0;
            chip_op    <= '0;
            chip_addr  <= '0;
            chip_wdata <= '0;
            state      <= S_RESP;
            if (chip_done[cur.ch]) begin
              rsp_status <= 2'b00;
              rsp_data   <= (cur.op == OP_WRITE) ? '0 : chip_rdata[cur.ch*DATA_W +: DATA_W];
            end else begin
              rsp_status <= 2'b01;
              rsp_data   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
            act        <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banzai_seq_ctrl.sv
// Bench for banzai_seq_ctrl (3 channels so that an out-of-range channel exists): directed timing scenarios plus a randomized scoreboard run.
module tb_banzai_seq_ctrl;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = '0;
  logic [1:0]  cmd_op = '0;
  logic [9:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic [3:0]  fifo_level;
  logic        busy;
  logic [2:0]  pwr_en;
  logic [2:0]  chip_sel;
  logic [1:0]  chip_op;
  logic [9:0]  chip_addr;
  logic [7:0]  chip_wdata;
  logic        chip_start;
  logic [2:0]  chip_done = '0;
  logic [23:0] chip_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_start = 0;

  banzai_seq_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(10), .DATA_W(DATA_W), .FIFO_DEPTH(8),
    .PWR_UP_CYCLES(16), .TIMEOUT(1023), .IDLE_OFF(256)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .fifo_level(fifo_level), .busy(busy), .pwr_en(pwr_en),
    .chip_sel(chip_sel), .chip_op(chip_op), .chip_addr(chip_addr), .chip_wdata(chip_wdata),
    .chip_start(chip_start), .chip_done(chip_done), .chip_rdata(chip_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (chip_start === 1'b1) n_start++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] ch;
    logic [1:0] op;
    logic [9:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
    int         dly;
  } rcmd_t;

  rcmd_t exp_q[$];
  rcmd_t iss_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [1:0] op, input logic [9:0] addr, input logic [7:0] data);
    cmd_ch = ch; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_chk++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_status, fifo_level, busy, pwr_en, chip_sel, chip_op, chip_addr, chip_wdata, chip_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {rsp_valid, rsp_data, rsp_status, fifo_level, busy, pwr_en, chip_sel, chip_op, chip_addr, chip_wdata, chip_start});
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_read_unpowered();
    int k;
    logic [7:0] wd;
    wd = 8'($urandom);
    push(2'd1, 2'b10, 10'h3A5, wd);
    tick();
    n_chk++;
    if (pwr_en !== 3'b010) begin n_fail++; $display("FAIL pwr_up_enable: got %b want 010", pwr_en); end
    k = 0;
    while (chip_start !== 1'b1 && k < 100) begin tick(); k++; end
    n_chk++;
    if (k != 16) begin n_fail++; $display("FAIL pwr_up_delay: got %0d cycles want 16", k); end
    n_chk++;
    if ({chip_sel, chip_op, chip_addr} !== {3'b010, 2'b10, 10'h3A5}) begin
      n_fail++; $display("FAIL issue_fields: got sel=%b op=%b addr=%h want 010/10/3a5", chip_sel, chip_op, chip_addr);
    end
    tick();
    n_chk++;
    if (chip_start !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle: got %b want 0", chip_start); end
    chip_done[1] = 1'b1;
    chip_rdata[15:8] = 8'h5C;
    tick();
    chip_done = '0;
    tick(); tick();
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_status} !== {1'b1, 8'h5C, 2'b00}) begin
      n_fail++; $display("FAIL read_rsp: got v=%b d=%h s=%b want 1/5c/00", rsp_valid, rsp_data, rsp_status);
    end
    n_chk++;
    if (chip_sel !== 3'b000) begin n_fail++; $display("FAIL sel_released: got %b want 000", chip_sel); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_consumed: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read_powered();
    int k, ks;
    push(2'd1, 2'b10, 10'($urandom), 8'($urandom));
    chip_done[1] = 1'b1;
    chip_rdata[15:8] = 8'hA7;
    k = 0; ks = -1;
    while (rsp_valid !== 1'b1 && k < 50) begin
      tick(); k++;
      if (chip_start === 1'b1) ks = k;
    end
    chip_done = '0;
    n_chk++;
    if (ks != 1) begin n_fail++; $display("FAIL powered_start_cycle: got %0d want 1", ks); end
    n_chk++;
    if (k != 3) begin n_fail++; $display("FAIL powered_rsp_latency: got %0d want 3", k); end
    n_chk++;
    if ({rsp_data, rsp_status, pwr_en} !== {8'hA7, 2'b00, 3'b010}) begin
      n_fail++; $display("FAIL powered_rsp: got d=%h s=%b pwr=%b want a7/00/010", rsp_data, rsp_status, pwr_en);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    k = 0;
    while (pwr_en[1] !== 1'b0 && k < 400) begin tick(); k++; end
    n_chk++;
    if (k != 256) begin n_fail++; $display("FAIL idle_power_down: got %0d cycles want 256", k); end
  endtask

  task automatic test_timeout();
    int k;
    logic [7:0] wd;
    wd = 8'($urandom);
    chip_done = 3'b011;
    chip_rdata = 24'($urandom);
    push(2'd2, 2'b11, 10'($urandom), wd);
    k = 0;
    while (chip_start !== 1'b1 && k < 100) begin tick(); k++; end
    n_chk++;
    if (k != 17) begin n_fail++; $display("FAIL infer_start_latency: got %0d want 17", k); end
    n_chk++;
    if ({chip_sel, chip_op, chip_wdata} !== {3'b100, 2'b11, wd}) begin
      n_fail++; $display("FAIL infer_fields: got sel=%b op=%b wd=%h want 100/11/%h", chip_sel, chip_op, chip_wdata, wd);
    end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 2000) begin tick(); k++; end
    chip_done = '0;
    n_chk++;
    if (k != 1025) begin n_fail++; $display("FAIL timeout_latency: got %0d want 1025", k); end
    n_chk++;
    if ({rsp_data, rsp_status} !== {8'h00, 2'b01}) begin
      n_fail++; $display("FAIL timeout_rsp: got d=%h s=%b want 00/01", rsp_data, rsp_status);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_chk++;
    if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL timeout_back_idle: got busy=%b v=%b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_full_fifo();
    int k, s0;
    logic [1:0] ch, op;
    logic [1:0] q[$];
    k = 0;
    while (pwr_en !== 3'b000 && k < 600) begin tick(); k++; end
    n_chk++;
    if (pwr_en !== 3'b000) begin n_fail++; $display("FAIL full_pre_idle: got %b want 000", pwr_en); end
    s0 = n_start;
    push(2'd0, 2'b00, 10'h0, 8'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      ch = 2'($urandom_range(0, 3));
      op = (ch == 2'd3) ? 2'($urandom_range(0, 3)) : 2'b00;
      push(ch, op, 10'($urandom), 8'($urandom));
      q.push_back((ch == 2'd3) ? 2'b10 : 2'b00);
    end
    n_chk++;
    if ({fifo_level, cmd_ready} !== {4'd8, 1'b0}) begin
      n_fail++; $display("FAIL fifo_full: got lvl=%0d rdy=%b want 8/0", fifo_level, cmd_ready);
    end
    cmd_ch = 2'd3; cmd_op = 2'b01; cmd_addr = 10'h155; cmd_data = 8'h99; cmd_valid = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_hold: got lvl=%0d want 8", fifo_level); end
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_status} !== {1'b1, 8'h00, 2'b00}) begin
      n_fail++; $display("FAIL nop_rsp: got v=%b d=%h s=%b want 1/00/00", rsp_valid, rsp_data, rsp_status);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    n_chk++;
    if ({cmd_ready, fifo_level} !== {1'b1, 4'd7}) begin
      n_fail++; $display("FAIL ready_after_pop: got rdy=%b lvl=%0d want 1/7", cmd_ready, fifo_level);
    end
    tick();
    cmd_valid = 1'b0;
    n_chk++;
    if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ninth_accepted: got lvl=%0d want 8", fifo_level); end
    q.push_back(2'b10);
    while (q.size() > 0) begin
      k = 0;
      while (rsp_valid !== 1'b1 && k < 20) begin tick(); k++; end
      n_chk++;
      if ({rsp_valid, rsp_data, rsp_status} !== {1'b1, 8'h00, q[0]}) begin
        n_fail++; $display("FAIL drain_rsp: got v=%b d=%h s=%b want 1/00/%b", rsp_valid, rsp_data, rsp_status, q[0]);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      void'(q.pop_front());
    end
    n_chk++;
    if (n_start != s0 || pwr_en !== 3'b000) begin
      n_fail++; $display("FAIL bad_nop_no_activity: got starts=%0d pwr=%b want 0/000", n_start - s0, pwr_en);
    end
  endtask

  task automatic test_rst_during_wait();
    int k, s0, r;
    push(2'd0, 2'b01, 10'($urandom), 8'($urandom));
    push(2'd1, 2'b10, 10'($urandom), 8'($urandom));
    k = 0;
    while (chip_start !== 1'b1 && k < 100) begin tick(); k++; end
    tick();
    n_chk++;
    if ({chip_sel, fifo_level} !== {3'b001, 4'd1}) begin
      n_fail++; $display("FAIL wait_before_rst: got sel=%b lvl=%0d want 001/1", chip_sel, fifo_level);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_status, fifo_level, busy, pwr_en, chip_sel, chip_op, chip_addr, chip_wdata, chip_start} !== '0) begin
      n_fail++;
      $display("FAIL rst_abort_outputs: got %h want 0",
               {cmd_ready, rsp_valid, rsp_data, rsp_status, fifo_level, busy, pwr_en, chip_sel, chip_op, chip_addr, chip_wdata, chip_start});
    end
    rst = 1'b0;
    s0 = n_start; r = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid === 1'b1) r++;
    end
    n_chk++;
    if ({cmd_ready, fifo_level, busy} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_flush: got rdy=%b lvl=%0d busy=%b want 1/0/0", cmd_ready, fifo_level, busy);
    end
    n_chk++;
    if (n_start != s0 || r != 0) begin
      n_fail++; $display("FAIL rst_no_activity: got starts=%0d rsp_cycles=%0d want 0/0", n_start - s0, r);
    end
  endtask

  task automatic test_random();
    localparam int N = 48;
    int  n_rsp;
    bit  all_done;
    n_rsp = 0;
    all_done = 1'b0;
    exp_q.delete();
    iss_q.delete();
    fork
      begin : drv
        for (int i = 0; i < N; i++) begin
          rcmd_t c;
          int    w;
          bit    acc;
          c.ch = 2'($urandom_range(0, 3)); c.op = 2'($urandom_range(0, 3));
          c.addr = 10'($urandom); c.data = 8'($urandom); c.rdata = 8'($urandom);
          c.dly = $urandom_range(0, 4);
          cmd_ch = c.ch; cmd_op = c.op; cmd_addr = c.addr; cmd_data = c.data; cmd_valid = 1'b1;
          acc = 1'b0; w = 0;
          while (!acc && w < 3000) begin
            acc = (cmd_ready === 1'b1);
            if (acc) begin
              exp_q.push_back(c);
              if (c.ch != 2'd3 && c.op != 2'b00) iss_q.push_back(c);
            end
            tick(); w++;
          end
          cmd_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin : resp
        while (!all_done) begin
          tick();
          if (chip_start === 1'b1) begin
            n_chk++;
            if (iss_q.size() == 0) begin
              n_fail++; $display("FAIL rand_spurious_start: got start with sel=%b want none", chip_sel);
            end else begin
              rcmd_t      c;
              logic [2:0] sel_exp;
              c = iss_q.pop_front();
              sel_exp = 3'b001 << c.ch;
              if ({chip_sel, chip_op, chip_addr} !== {sel_exp, c.op, c.addr} ||
                  (c.op != 2'b10 && chip_wdata !== c.data)) begin
                n_fail++;
                $display("FAIL rand_issue: got sel=%b op=%b addr=%h wd=%h want %b/%b/%h/%h",
                         chip_sel, chip_op, chip_addr, chip_wdata, sel_exp, c.op, c.addr, c.data);
              end
              repeat (c.dly + 1) tick();
              chip_done[c.ch] = 1'b1;
              chip_rdata[c.ch*DATA_W +: DATA_W] = c.rdata;
              tick();
              chip_done = '0;
            end
          end
        end
      end
      begin : cons
        int k;
        k = 0;
        while (n_rsp < N && k < 20000) begin
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            rcmd_t      e;
            logic [1:0] s_exp;
            logic [7:0] d_exp;
            n_chk++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_extra_rsp: got d=%h s=%b want no response", rsp_data, rsp_status);
            end else begin
              e = exp_q.pop_front();
              s_exp = (e.ch == 2'd3) ? 2'b10 : 2'b00;
              d_exp = (e.ch == 2'd3 || e.op == 2'b00 || e.op == 2'b01) ? 8'h00 : e.rdata;
              if ({rsp_data, rsp_status} !== {d_exp, s_exp}) begin
                n_fail++; $display("FAIL rand_rsp: got d=%h s=%b want %h/%b (ch=%0d op=%b)",
                                   rsp_data, rsp_status, d_exp, s_exp, e.ch, e.op);
              end
            end
            n_rsp++;
          end
          tick(); k++;
        end
        rsp_ready = 1'b0;
        n_chk++;
        if (n_rsp != N) begin n_fail++; $display("FAIL rand_rsp_count: got %0d want %0d", n_rsp, N); end
        all_done = 1'b1;
      end
    join
  endtask

  initial begin
    test_reset();
    test_read_unpowered();
    test_read_powered();
    test_timeout();
    test_full_fifo();
    test_rst_during_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
